// File: rtl/fwd_scoreboard_pkg.sv
// Shared definitions for the operand-forwarding scoreboard.
// Holds the default data/address widths and the entry field layout
// {v, wa, rdy, data} so decode, register file and the scoreboard agree.
package fwd_scoreboard_pkg;

   localparam int unsigned FwdDw     = 32;
   localparam int unsigned FwdAw     = 5;
   localparam int unsigned FwdNstage = 3;
   localparam int unsigned FwdNport  = 2;

   // Packed entry is {v, wa[aw-1:0], rdy, data[dw-1:0]}, msb first.
   function automatic int unsigned entry_width(input int unsigned dw, input int unsigned aw);
      return dw + aw + 2;
   endfunction

endpackage

// File: rtl/fwd_scoreboard_if.sv
// Bus bundle between the decode/issue logic and the forwarding scoreboard.
// slave  : seen by the scoreboard (issue, read, result inputs; operand/writeback outputs)
// master : seen by the issue side / environment driving the scoreboard
interface fwd_scoreboard_if #(
   parameter int unsigned DW     = fwd_scoreboard_pkg::FwdDw,
   parameter int unsigned AW     = fwd_scoreboard_pkg::FwdAw,
   parameter int unsigned NSTAGE = fwd_scoreboard_pkg::FwdNstage,
   parameter int unsigned NPORT  = fwd_scoreboard_pkg::FwdNport
) ();

   logic                  flush;
   logic                  iss_valid;
   logic                  iss_we;
   logic [AW-1:0]         iss_wa;
   logic                  iss_rdy;
   logic [DW-1:0]         iss_data;
   logic [NPORT-1:0]      rd_en;
   logic [NPORT*AW-1:0]   rd_addr;
   logic [NPORT*DW-1:0]   rd_rf_data;
   logic [NSTAGE-1:0]     res_valid;
   logic [NSTAGE*DW-1:0]  res_data;
   logic [NPORT*DW-1:0]   rd_data;
   logic [NPORT-1:0]      rd_fwd;
   logic                  stall;
   logic                  wb_valid;
   logic [AW-1:0]         wb_addr;
   logic [DW-1:0]         wb_data;
   logic                  wb_err;

   modport slave (
      input  flush, iss_valid, iss_we, iss_wa, iss_rdy, iss_data,
      input  rd_en, rd_addr, rd_rf_data, res_valid, res_data,
      output rd_data, rd_fwd, stall, wb_valid, wb_addr, wb_data, wb_err
   );

   modport master (
      output flush, iss_valid, iss_we, iss_wa, iss_rdy, iss_data,
      output rd_en, rd_addr, rd_rf_data, res_valid, res_data,
      input  rd_data, rd_fwd, stall, wb_valid, wb_addr, wb_data, wb_err
   );

endinterface

// File: rtl/fwd_scoreboard_stage.sv
// One tracked pipeline entry {v, wa, rdy, data} with result capture.
// Ports:
//   clk, reset_n          clock, async active-low reset
//   flush_i               clear the entry on the next edge
//   in_*_i                entry loaded on the next edge (from issue or the previous stage)
//   res_valid_i/res_data_i  result produced by this stage this cycle
//   v_o, wa_o             stored valid and destination
//   rdy_o, data_o         ready/data including a same-cycle captured result
module fwd_scoreboard_stage
   import fwd_scoreboard_pkg::*;
#(
   parameter int unsigned DW = FwdDw,
   parameter int unsigned AW = FwdAw
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          flush_i,
   input  logic          in_v_i,
   input  logic [AW-1:0] in_wa_i,
   input  logic          in_rdy_i,
   input  logic [DW-1:0] in_data_i,
   input  logic          res_valid_i,
   input  logic [DW-1:0] res_data_i,
   output logic          v_o,
   output logic [AW-1:0] wa_o,
   output logic          rdy_o,
   output logic [DW-1:0] data_o
);

   localparam int unsigned EW = entry_width(DW, AW);

   logic [EW-1:0] entry_q, entry_d;
   logic          cur_v, cur_rdy;
   logic [AW-1:0] cur_wa;
   logic [DW-1:0] cur_data;

   assign {cur_v, cur_wa, cur_rdy, cur_data} = entry_q;

   always_comb begin
      entry_d = {in_v_i, in_wa_i, in_rdy_i, in_data_i};
      if (flush_i) entry_d = '0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) entry_q <= '0;
      else          entry_q <= entry_d;
   end

   // A ready entry keeps its stored data, so a late res_valid never overwrites it.
   assign v_o    = cur_v;
   assign wa_o   = cur_wa;
   assign rdy_o  = cur_rdy | (cur_v & res_valid_i);
   assign data_o = cur_rdy ? cur_data : res_data_i;

endmodule

// File: rtl/fwd_scoreboard.sv
// Operand-forwarding and RAW-hazard scoreboard for the pipelined MIPS core.
// Tracks in-flight register writes over NSTAGE stages, resolves NPORT operand reads
// with the youngest value, raises stall when that value does not exist yet, and
// drives the register-file write port from the last stage.
// Ports:
//   clk, reset_n   clock, async active-low reset
//   bus (slave)    issue, operand read, stage result, operand out, writeback, wb_err
module fwd_scoreboard
   import fwd_scoreboard_pkg::*;
#(
   parameter int unsigned DW     = FwdDw,
   parameter int unsigned AW     = FwdAw,
   parameter int unsigned NSTAGE = FwdNstage,
   parameter int unsigned NPORT  = FwdNport
) (
   input  logic           clk,
   input  logic           reset_n,
   fwd_scoreboard_if.slave bus
);

   localparam int unsigned Last = NSTAGE - 1;

   logic [NSTAGE-1:0] st_v, st_rdy;
   logic [AW-1:0]     st_wa   [NSTAGE];
   logic [DW-1:0]     st_data [NSTAGE];

   logic [NSTAGE-1:0] ld_v, ld_rdy;
   logic [AW-1:0]     ld_wa   [NSTAGE];
   logic [DW-1:0]     ld_data [NSTAGE];

   logic [NPORT-1:0]  hazard, fwd;
   logic              stall;
   logic              wb_err_q, wb_err_d;

   // Entry chain: stage 0 takes the accepted issue (or a bubble), older stages shift.
   for (genvar s = 0; s < NSTAGE; s++) begin : g_stage
      if (s == 0) begin : g_head
         assign ld_v[s]    = bus.iss_valid & bus.iss_we & ~stall;
         assign ld_wa[s]   = bus.iss_wa;
         assign ld_rdy[s]  = bus.iss_rdy;
         assign ld_data[s] = bus.iss_data;
      end else begin : g_body
         assign ld_v[s]    = st_v[s-1];
         assign ld_wa[s]   = st_wa[s-1];
         assign ld_rdy[s]  = st_rdy[s-1];
         assign ld_data[s] = st_data[s-1];
      end

      fwd_scoreboard_stage #(
         .DW (DW),
         .AW (AW)
      ) u_stage (
         .clk         (clk),
         .reset_n     (reset_n),
         .flush_i     (bus.flush),
         .in_v_i      (ld_v[s]),
         .in_wa_i     (ld_wa[s]),
         .in_rdy_i    (ld_rdy[s]),
         .in_data_i   (ld_data[s]),
         .res_valid_i (bus.res_valid[s]),
         .res_data_i  (bus.res_data[s*DW +: DW]),
         .v_o         (st_v[s]),
         .wa_o        (st_wa[s]),
         .rdy_o       (st_rdy[s]),
         .data_o      (st_data[s])
      );
   end

   // Per-port lookup: first valid match from youngest to oldest decides.
   for (genvar p = 0; p < NPORT; p++) begin : g_port
      logic [AW-1:0] addr;
      logic [DW-1:0] rf;
      logic          hit_c, haz_c;
      logic [DW-1:0] dat_c;

      assign addr = bus.rd_addr[p*AW +: AW];
      assign rf   = bus.rd_rf_data[p*DW +: DW];

      always_comb begin
         hit_c = 1'b0;
         haz_c = 1'b0;
         dat_c = rf;
         if (bus.rd_en[p] && (addr != '0)) begin
            for (int unsigned s = 0; s < NSTAGE; s++) begin
               if (!hit_c && st_v[s] && (st_wa[s] == addr)) begin
                  hit_c = 1'b1;
                  if (st_rdy[s]) dat_c = st_data[s];
                  else           haz_c = 1'b1;
               end
            end
         end
      end

      assign hazard[p]                 = haz_c;
      assign fwd[p]                    = hit_c & ~haz_c;
      assign bus.rd_data[p*DW +: DW]   = dat_c;
   end

   assign stall      = bus.iss_valid & (|hazard);
   assign bus.stall  = stall;
   assign bus.rd_fwd = fwd;

   // Writeback commits even when flush is asserted in the same cycle.
   assign bus.wb_valid = st_v[Last] & (st_wa[Last] != '0);
   assign bus.wb_addr  = st_wa[Last];
   assign bus.wb_data  = st_data[Last];

   always_comb begin
      wb_err_d = wb_err_q | (st_v[Last] & ~st_rdy[Last]);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) wb_err_q <= 1'b0;
      else          wb_err_q <= wb_err_d;
   end

   assign bus.wb_err = wb_err_q;

endmodule

// File: tb/tb_fwd_scoreboard.sv
module tb_fwd_scoreboard;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NS = 3;
   localparam int NP = 2;

   logic clk = 1'b1;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   fwd_scoreboard_if #(.DW(DW), .AW(AW), .NSTAGE(NS), .NPORT(NP)) bus ();

   fwd_scoreboard #(.DW(DW), .AW(AW), .NSTAGE(NS), .NPORT(NP)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   // Reference model: list of in-flight writes, each tagged with its current stage.
   typedef struct {
      logic [AW-1:0] wa;
      logic          rdy;
      logic [DW-1:0] data;
      int            stg;
   } fl_t;

   typedef struct {
      logic             stall;
      logic [NP*DW-1:0] d;
      logic [NP-1:0]    fwd;
      logic [NP-1:0]    care;
      logic             wbv;
      logic [AW-1:0]    wba;
      logic [DW-1:0]    wbd;
      logic             wbd_care;
      logic             err;
   } exp_t;

   fl_t  fl[$];
   exp_t sb[$];
   bit   err_m = 1'b0;
   int   n_tests = 0;
   int   n_fail = 0;

   task automatic xchk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int youngest(input logic [AW-1:0] a);
      int best = -1;
      for (int i = 0; i < fl.size(); i++)
         if (fl[i].wa == a && (best < 0 || fl[i].stg < fl[best].stg)) best = i;
      return best;
   endfunction

   function automatic exp_t predict();
      exp_t e;
      logic haz = 1'b0;
      e.d = bus.rd_rf_data;
      e.fwd = '0;
      e.care = '1;
      for (int p = 0; p < NP; p++) begin
         logic [AW-1:0] a;
         int i;
         a = bus.rd_addr[p*AW +: AW];
         if (bus.rd_en[p] && a != 0) begin
            i = youngest(a);
            if (i >= 0) begin
               if (fl[i].rdy) begin
                  e.d[p*DW +: DW] = fl[i].data;
                  e.fwd[p] = 1'b1;
               end else if (bus.res_valid[fl[i].stg]) begin
                  e.d[p*DW +: DW] = bus.res_data[fl[i].stg*DW +: DW];
                  e.fwd[p] = 1'b1;
               end else begin
                  haz = 1'b1;
                  e.care[p] = 1'b0;
               end
            end
         end
      end
      e.stall = bus.iss_valid & haz;
      e.wbv = 1'b0;
      e.wba = '0;
      e.wbd = '0;
      e.wbd_care = 1'b0;
      foreach (fl[i]) begin
         if (fl[i].stg == NS-1) begin
            e.wbv = (fl[i].wa != 0);
            e.wba = fl[i].wa;
            if (fl[i].rdy) begin
               e.wbd = fl[i].data;
               e.wbd_care = e.wbv;
            end else if (bus.res_valid[NS-1]) begin
               e.wbd = bus.res_data[(NS-1)*DW +: DW];
               e.wbd_care = e.wbv;
            end
         end
      end
      e.err = err_m;
      return e;
   endfunction

   // Apply the edge that just happened, using the inputs still on the bus.
   task automatic advance();
      exp_t e;
      bit acc;
      if (!reset_n) begin
         fl.delete();
         err_m = 1'b0;
         return;
      end
      e = predict();
      acc = bus.iss_valid & bus.iss_we & ~e.stall & ~bus.flush;
      foreach (fl[i]) begin
         if (!fl[i].rdy && bus.res_valid[fl[i].stg]) begin
            fl[i].rdy = 1'b1;
            fl[i].data = bus.res_data[fl[i].stg*DW +: DW];
         end
         if (fl[i].stg == NS-1 && !fl[i].rdy) err_m = 1'b1;
      end
      if (bus.flush) fl.delete();
      else begin
         foreach (fl[i]) fl[i].stg++;
         for (int i = fl.size()-1; i >= 0; i--) if (fl[i].stg >= NS) fl.delete(i);
      end
      if (acc) fl.push_back('{wa: bus.iss_wa, rdy: bus.iss_rdy, data: bus.iss_data, stg: 0});
   endtask

   task automatic cycle();
      sb.push_back(predict());
      @(posedge clk);
      #1;
      advance();
   endtask

   task automatic idle();
      bus.flush      = 1'b0;
      bus.iss_valid  = 1'b0;
      bus.iss_we     = 1'b0;
      bus.iss_wa     = '0;
      bus.iss_rdy    = 1'b0;
      bus.iss_data   = '0;
      bus.rd_en      = '0;
      bus.rd_addr    = '0;
      bus.rd_rf_data = {$urandom, $urandom};
      bus.res_valid  = '0;
      bus.res_data   = {$urandom, $urandom, $urandom};
   endtask

   task automatic issue(input logic [AW-1:0] wa, input logic rdy, input logic [DW-1:0] d);
      idle();
      bus.iss_valid = 1'b1;
      bus.iss_we    = 1'b1;
      bus.iss_wa    = wa;
      bus.iss_rdy   = rdy;
      bus.iss_data  = d;
   endtask

   task automatic rand_inputs(input bit no_err);
      idle();
      bus.flush     = ($urandom_range(0, 19) == 0);
      bus.iss_valid = $urandom_range(0, 3) != 0;
      bus.iss_we    = $urandom_range(0, 3) != 0;
      bus.iss_wa    = AW'($urandom_range(0, 7));
      bus.iss_rdy   = $urandom_range(0, 1) != 0;
      bus.iss_data  = $urandom;
      bus.rd_en     = NP'($urandom);
      bus.rd_addr   = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
      bus.res_valid = NS'($urandom);
      if (no_err)
         foreach (fl[i]) if (fl[i].stg == NS-1 && !fl[i].rdy) bus.res_valid[NS-1] = 1'b1;
   endtask

   // Monitor: pops the expected response for each cycle and compares.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            xchk("stall", bus.stall, e.stall);
            for (int p = 0; p < NP; p++) begin
               if (e.care[p]) begin
                  xchk($sformatf("rd_data%0d", p), bus.rd_data[p*DW +: DW], e.d[p*DW +: DW]);
                  xchk($sformatf("rd_fwd%0d", p), bus.rd_fwd[p], e.fwd[p]);
               end
            end
            xchk("wb_valid", bus.wb_valid, e.wbv);
            if (e.wbv) xchk("wb_addr", bus.wb_addr, e.wba);
            if (e.wbd_care) xchk("wb_data", bus.wb_data, e.wbd);
            xchk("wb_err", bus.wb_err, e.err);
         end
      end
   end

   initial begin
      // Reset with random inputs.
      reset_n = 1'b0;
      repeat (3) begin
         rand_inputs(1'b0);
         #1;
         xchk("rst_stall", bus.stall, 1'b0);
         xchk("rst_wb_valid", bus.wb_valid, 1'b0);
         xchk("rst_wb_err", bus.wb_err, 1'b0);
         xchk("rst_rd_fwd", bus.rd_fwd, '0);
         xchk("rst_rd_data", bus.rd_data, bus.rd_rf_data);
         cycle();
      end
      reset_n = 1'b1;

      // ALU chain.
      issue(5'd8, 1'b1, 32'h0000_1234);
      cycle();
      idle();
      bus.iss_valid = 1'b1;
      bus.rd_en     = 2'b01;
      bus.rd_addr   = {5'd0, 5'd8};
      #1;
      xchk("alu_data", bus.rd_data[DW-1:0], 32'h0000_1234);
      xchk("alu_fwd", bus.rd_fwd[0], 1'b1);
      xchk("alu_stall", bus.stall, 1'b0);
      cycle();
      idle();
      cycle();
      idle();
      #1;
      xchk("alu_wb_valid", bus.wb_valid, 1'b1);
      xchk("alu_wb_addr", bus.wb_addr, 5'd8);
      xchk("alu_wb_data", bus.wb_data, 32'h0000_1234);
      cycle();

      // Load-use hazard, resolved by a same-cycle result from stage 1.
      issue(5'd9, 1'b0, $urandom);
      cycle();
      issue(5'd12, 1'b1, 32'h55);
      bus.rd_en   = 2'b01;
      bus.rd_addr = {5'd0, 5'd9};
      #1;
      xchk("lu_stall", bus.stall, 1'b1);
      cycle();
      issue(5'd12, 1'b1, 32'h55);
      bus.rd_en     = 2'b01;
      bus.rd_addr   = {5'd0, 5'd9};
      bus.res_valid = 3'b010;
      bus.res_data[2*DW-1:DW] = 32'hDEAD_BEEF;
      #1;
      xchk("lu_stall_clr", bus.stall, 1'b0);
      xchk("lu_data", bus.rd_data[DW-1:0], 32'hDEAD_BEEF);
      xchk("lu_fwd", bus.rd_fwd[0], 1'b1);
      cycle();
      repeat (4) begin
         idle();
         cycle();
      end

      // Priority: youngest of two writes to r5 wins, then retirement restores rf.
      issue(5'd5, 1'b1, 32'h1);
      cycle();
      issue(5'd5, 1'b1, 32'h2);
      cycle();
      idle();
      bus.rd_en   = 2'b10;
      bus.rd_addr = {5'd5, 5'd0};
      #1;
      xchk("prio_data", bus.rd_data[2*DW-1:DW], 32'h2);
      cycle();
      idle();
      cycle();
      idle();
      cycle();
      idle();
      bus.rd_en   = 2'b10;
      bus.rd_addr = {5'd5, 5'd0};
      #1;
      xchk("prio_rf_data", bus.rd_data[2*DW-1:DW], bus.rd_rf_data[2*DW-1:DW]);
      xchk("prio_rf_fwd", bus.rd_fwd[1], 1'b0);
      cycle();

      // Register 0 is tracked but never forwarded or written back.
      issue(5'd0, 1'b1, 32'h0000_FFFF);
      cycle();
      idle();
      bus.rd_en   = 2'b01;
      bus.rd_addr = {5'd0, 5'd0};
      #1;
      xchk("r0_data", bus.rd_data[DW-1:0], bus.rd_rf_data[DW-1:0]);
      xchk("r0_fwd", bus.rd_fwd[0], 1'b0);
      cycle();
      idle();
      cycle();
      idle();
      #1;
      xchk("r0_wb_valid", bus.wb_valid, 1'b0);
      cycle();

      // Flush during a stall.
      issue(5'd10, 1'b0, $urandom);
      cycle();
      idle();
      bus.iss_valid = 1'b1;
      bus.rd_en     = 2'b01;
      bus.rd_addr   = {5'd0, 5'd10};
      bus.flush     = 1'b1;
      #1;
      xchk("fl_stall", bus.stall, 1'b1);
      cycle();
      idle();
      bus.iss_valid = 1'b1;
      bus.rd_en     = 2'b01;
      bus.rd_addr   = {5'd0, 5'd10};
      #1;
      xchk("fl_stall_clr", bus.stall, 1'b0);
      xchk("fl_fwd", bus.rd_fwd[0], 1'b0);
      cycle();
      repeat (3) begin
         idle();
         cycle();
      end

      // Randomized traffic against the model.
      repeat (500) begin
         rand_inputs(1'b1);
         cycle();
      end
      repeat (3) begin
         idle();
         cycle();
      end

      // Asynchronous reset mid-operation.
      issue(5'd3, 1'b1, 32'hA5A5_0003);
      cycle();
      repeat (2) begin
         idle();
         cycle();
      end
      idle();
      #1;
      xchk("ar_wb_pre", bus.wb_valid, 1'b1);
      reset_n = 1'b0;
      fl.delete();
      err_m = 1'b0;
      #1;
      xchk("ar_wb_async", bus.wb_valid, 1'b0);
      cycle();
      reset_n = 1'b1;

      // Unready entry reaches writeback: sticky error.
      issue(5'd11, 1'b0, $urandom);
      cycle();
      repeat (2) begin
         idle();
         cycle();
      end
      idle();
      #1;
      xchk("err_wb_valid", bus.wb_valid, 1'b1);
      xchk("err_pre", bus.wb_err, 1'b0);
      cycle();
      idle();
      #1;
      xchk("err_set", bus.wb_err, 1'b1);
      cycle();
      repeat (40) begin
         rand_inputs(1'b0);
         cycle();
      end
      idle();
      #1;
      xchk("err_sticky", bus.wb_err, 1'b1);
      cycle();

      xchk("sb_drain", 64'(sb.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
